// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states, requester IDs, word width.
package mem_arbiter_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } req_id_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and single-port memory side of mem_arbiter.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic  if_req;
    word_t if_addr;
    logic  if_gnt;
    logic  if_rvalid;
    word_t if_rdata;

    logic  d_req;
    logic  d_we;
    word_t d_addr;
    word_t d_wdata;
    logic  d_gnt;
    logic  d_rvalid;
    word_t d_rdata;

    logic  m_en;
    logic  m_we;
    word_t m_addr;
    word_t m_wdata;
    word_t m_rdata;

    // Requesters plus the memory model sit on the master side
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               m_en, m_we, m_addr, m_wdata
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               m_en, m_we, m_addr, m_wdata
    );

endinterface

// File: rtl/mem_arbiter_arb_counter.sv
// Small counter used for latency countdown and fetch-starvation tracking.
module arb_counter #(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    // Priority: clear, load, decrement (floor at 0), saturating increment
    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (load) begin
            count_next = load_val;
        end else if (dec) begin
            if (count_reg != '0) count_next = count_reg - 1'b1;
        end else if (inc) begin
            if (count_reg < MAX_V) count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_reg <= '0;
        else        count_reg <= count_next;
    end

    assign count = count_reg;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter for a single-port memory, one access in flight.
// Define MEM_ARB_RR_EN for two-way round-robin instead of data priority with starvation guard.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LAT        = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    state_t  state_reg, state_next;
    req_id_t owner_reg;
    logic    we_reg;
    logic    if_rvalid_reg, d_rvalid_reg;
    word_t   if_rdata_reg, d_rdata_reg;

    logic       grant_fetch, grant_data;
    logic       lat_load, lat_dec, done;
    logic [1:0] lat_count;
    logic       data_wins;

    arb_counter #(.W(2), .MAX(3)) u_lat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (1'b0),
        .load     (lat_load),
        .load_val (2'(LAT - 1)),
        .dec      (lat_dec),
        .inc      (1'b0),
        .count    (lat_count)
    );

`ifdef MEM_ARB_RR_EN
    req_id_t ptr_reg;

    assign data_wins = bus.d_req && !(bus.if_req && ptr_reg == FETCH);

    // The requester that just won yields priority on the next conflict
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           ptr_reg <= FETCH;
        else if (grant_fetch) ptr_reg <= DATA;
        else if (grant_data)  ptr_reg <= FETCH;
    end
`else
    logic [3:0] starve_count;
    logic       starve_clr, starve_inc;

    assign starve_clr = grant_fetch || (state_reg == IDLE && !bus.if_req);
    assign starve_inc = grant_data && bus.if_req;
    assign data_wins  = bus.d_req && !(bus.if_req && starve_count == 4'(STARVE_MAX));

    arb_counter #(.W(4), .MAX(STARVE_MAX)) u_starve_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (starve_clr),
        .load     (1'b0),
        .load_val (4'd0),
        .dec      (1'b0),
        .inc      (starve_inc),
        .count    (starve_count)
    );
`endif

    always_comb begin
        state_next  = state_reg;
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        lat_load    = 1'b0;
        lat_dec     = 1'b0;
        done        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    grant_data  = data_wins;
                    grant_fetch = !data_wins;
                    lat_load    = 1'b1;
                    state_next  = WAIT;
                end
            end
            WAIT: begin
                // Counter hits zero in the cycle the memory presents read data
                if (lat_count == 2'd0) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end else begin
                    lat_dec = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            owner_reg     <= FETCH;
            we_reg        <= 1'b0;
            if_rvalid_reg <= 1'b0;
            d_rvalid_reg  <= 1'b0;
            if_rdata_reg  <= '0;
            d_rdata_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            if_rvalid_reg <= done && owner_reg == FETCH;
            d_rvalid_reg  <= done && owner_reg == DATA;
            if (grant_fetch || grant_data) begin
                owner_reg <= grant_data ? DATA : FETCH;
                we_reg    <= grant_data && bus.d_we;
            end
            if (done) begin
                if (owner_reg == FETCH) if_rdata_reg <= bus.m_rdata;
                else                    d_rdata_reg  <= we_reg ? '0 : bus.m_rdata;
            end
        end
    end

    assign bus.if_gnt    = grant_fetch;
    assign bus.d_gnt     = grant_data;
    assign bus.m_en      = grant_fetch || grant_data;
    assign bus.m_we      = grant_data && bus.d_we;
    assign bus.m_addr    = grant_data ? bus.d_addr : (grant_fetch ? bus.if_addr : '0);
    assign bus.m_wdata   = grant_data ? bus.d_wdata : '0;
    assign bus.if_rvalid = if_rvalid_reg;
    assign bus.d_rvalid  = d_rvalid_reg;
    assign bus.if_rdata  = if_rdata_reg;
    assign bus.d_rdata   = d_rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table on a LAT=1 instance, corner sequences on LAT=3.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_if a_bus ();
    mem_arbiter_if b_bus ();

    mem_arbiter #(.LAT(1), .STARVE_MAX(4)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(a_bus.slave));
    mem_arbiter #(.LAT(3), .STARVE_MAX(4)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b_bus.slave));

    typedef struct {
        logic        if_req;
        logic        d_req;
        logic        d_we;
        logic [15:0] if_addr;
        logic [15:0] d_addr;
        logic [15:0] d_wdata;
        logic [15:0] mem;
        logic [1:0]  exp_gnt;   // {d, if}
        logic        exp_we;
        logic [15:0] exp_addr;
        logic [15:0] exp_rdata;
    } vec_t;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic idle_inputs();
        a_bus.if_req = 0; a_bus.d_req = 0; a_bus.d_we = 0;
        a_bus.if_addr = '0; a_bus.d_addr = '0; a_bus.d_wdata = '0; a_bus.m_rdata = '0;
        b_bus.if_req = 0; b_bus.d_req = 0; b_bus.d_we = 0;
        b_bus.if_addr = '0; b_bus.d_addr = '0; b_bus.d_wdata = '0; b_bus.m_rdata = '0;
    endtask

    initial begin
        vec_t       vecs [7];
        logic [1:0] exp_seq [10];
        int         n;
        int         last;

        // if_req d_req we  if_addr   d_addr    d_wdata   mem       gnt   we  addr      rdata
        vecs[0] = '{1, 0, 0, 16'h0003, 16'h0000, 16'h0000, 16'hA5A5, 2'b01, 0, 16'h0003, 16'hA5A5};
        vecs[1] = '{0, 1, 0, 16'h0000, 16'h0020, 16'h0000, 16'h5A5A, 2'b10, 0, 16'h0020, 16'h5A5A};
        vecs[2] = '{0, 1, 1, 16'h0000, 16'h0010, 16'h1234, 16'hCCCC, 2'b10, 1, 16'h0010, 16'h0000};
`ifdef MEM_ARB_RR_EN
        vecs[3] = '{1, 1, 0, 16'h0100, 16'h0200, 16'h0000, 16'h0F0F, 2'b01, 0, 16'h0100, 16'h0F0F};
`else
        vecs[3] = '{1, 1, 0, 16'h0100, 16'h0200, 16'h0000, 16'h0F0F, 2'b10, 0, 16'h0200, 16'h0F0F};
`endif
        vecs[4] = '{0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h7777, 2'b00, 0, 16'h0000, 16'h0000};
        vecs[5] = '{1, 0, 0, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 2'b01, 0, 16'hFFFF, 16'hFFFF};
        vecs[6] = '{1, 1, 1, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h9999, 2'b10, 1, 16'hFFFF, 16'h0000};

`ifdef MEM_ARB_RR_EN
        for (int i = 0; i < 10; i++) exp_seq[i] = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
        for (int i = 0; i < 10; i++) exp_seq[i] = (i == 4 || i == 9) ? 2'b01 : 2'b10;
`endif

        // Reset state
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        check("rst_gnt_a",    {a_bus.d_gnt, a_bus.if_gnt, a_bus.m_en}, 3'b000);
        check("rst_rvalid_a", {a_bus.d_rvalid, a_bus.if_rvalid}, 2'b00);
        check("rst_rdata_a",  {a_bus.d_rdata, a_bus.if_rdata}, 32'h0);
        check("rst_rvalid_b", {b_bus.d_rvalid, b_bus.if_rvalid}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        // Both requesters held high: arbitration order and one access per LAT+1 cycles
        @(negedge clk);
        a_bus.if_req = 1; a_bus.d_req = 1; a_bus.d_we = 0;
        a_bus.if_addr = 16'h0100; a_bus.d_addr = 16'h0200;
        n = 0;
        last = 0;
        for (int cyc = 0; cyc < 40 && n < 10; cyc++) begin
            #1;
            if (a_bus.if_gnt || a_bus.d_gnt) begin
                check("arb_seq", {a_bus.d_gnt, a_bus.if_gnt}, exp_seq[n]);
                if (n > 0) begin
                    check("arb_gap", 32'(cyc - last), 32'd2);
                    check("arb_prev_rvalid", {a_bus.d_rvalid, a_bus.if_rvalid}, exp_seq[n-1]);
                end
                $display("arb grant %0d: d_gnt=%b if_gnt=%b cycle=%0d", n, a_bus.d_gnt, a_bus.if_gnt, cyc);
                last = cyc;
                n++;
            end
            @(negedge clk);
        end
        check("arb_count", n, 10);
        a_bus.if_req = 0; a_bus.d_req = 0;
        repeat (3) @(negedge clk);

        // Single-access vectors on the LAT=1 instance
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            a_bus.if_req = vecs[i].if_req; a_bus.d_req = vecs[i].d_req; a_bus.d_we = vecs[i].d_we;
            a_bus.if_addr = vecs[i].if_addr; a_bus.d_addr = vecs[i].d_addr;
            a_bus.d_wdata = vecs[i].d_wdata; a_bus.m_rdata = 16'hDEAD;
            #1;
            check("vec_gnt", {a_bus.d_gnt, a_bus.if_gnt}, vecs[i].exp_gnt);
            check("vec_m_en", a_bus.m_en, |vecs[i].exp_gnt);
            if (|vecs[i].exp_gnt) begin
                check("vec_m_we", a_bus.m_we, vecs[i].exp_we);
                check("vec_m_addr", a_bus.m_addr, vecs[i].exp_addr);
            end
            if (vecs[i].exp_gnt[1]) check("vec_m_wdata", a_bus.m_wdata, vecs[i].d_wdata);
            @(negedge clk);
            a_bus.if_req = 0; a_bus.d_req = 0; a_bus.m_rdata = vecs[i].mem;
            #1;
            check("vec_wait_out", {a_bus.d_gnt, a_bus.if_gnt, a_bus.m_en, a_bus.m_we}, 4'b0000);
            check("vec_wait_rvalid", {a_bus.d_rvalid, a_bus.if_rvalid}, 2'b00);
            @(negedge clk);
            a_bus.m_rdata = 16'hBEEF;
            #1;
            check("vec_rvalid", {a_bus.d_rvalid, a_bus.if_rvalid}, vecs[i].exp_gnt);
            if (vecs[i].exp_gnt[0]) check("vec_if_rdata", a_bus.if_rdata, vecs[i].exp_rdata);
            if (vecs[i].exp_gnt[1]) check("vec_d_rdata", a_bus.d_rdata, vecs[i].exp_rdata);
            $display("vec %0d: gnt=%b%b rvalid=%b%b if_rdata=%h d_rdata=%h", i,
                     vecs[i].exp_gnt[1], vecs[i].exp_gnt[0], a_bus.d_rvalid, a_bus.if_rvalid,
                     a_bus.if_rdata, a_bus.d_rdata);
        end

        // LAT=3: data request raised during a fetch WAIT is held off until IDLE
        @(negedge clk);
        b_bus.if_req = 1; b_bus.if_addr = 16'h0042; b_bus.m_rdata = 16'hDEAD;
        #1;
        check("hold_if_gnt", b_bus.if_gnt, 1'b1);
        @(negedge clk);
        b_bus.if_req = 0; b_bus.d_req = 1; b_bus.d_we = 0; b_bus.d_addr = 16'h0077;
        #1;
        check("hold_d_gnt_w1", {b_bus.d_gnt, b_bus.m_en}, 2'b00);
        @(negedge clk);
        #1;
        check("hold_d_gnt_w2", b_bus.d_gnt, 1'b0);
        @(negedge clk);
        b_bus.m_rdata = 16'h1111;
        #1;
        check("hold_d_gnt_w3", b_bus.d_gnt, 1'b0);
        @(negedge clk);
        b_bus.m_rdata = 16'hDEAD;
        #1;
        check("hold_if_rvalid", b_bus.if_rvalid, 1'b1);
        check("hold_if_rdata", b_bus.if_rdata, 16'h1111);
        check("hold_d_gnt", {b_bus.d_gnt, b_bus.m_en}, 2'b11);
        check("hold_m_addr", b_bus.m_addr, 16'h0077);
        $display("hold: fetch rdata=%h, data granted with addr=%h", b_bus.if_rdata, b_bus.m_addr);
        @(negedge clk);
        b_bus.d_req = 0;
        #1;
        check("hold_if_rvalid_once", b_bus.if_rvalid, 1'b0);
        @(negedge clk);
        @(negedge clk);
        b_bus.m_rdata = 16'h2222;
        @(negedge clk);
        b_bus.m_rdata = 16'hDEAD;
        #1;
        check("hold_d_rvalid", b_bus.d_rvalid, 1'b1);
        check("hold_d_rdata", b_bus.d_rdata, 16'h2222);
        $display("hold: data load rdata=%h", b_bus.d_rdata);

        // LAT=3: reset two cycles into a fetch aborts it silently
        @(negedge clk);
        b_bus.if_req = 1; b_bus.if_addr = 16'h0005;
        #1;
        check("abort_if_gnt", b_bus.if_gnt, 1'b1);
        @(negedge clk);
        b_bus.if_req = 0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_rst_out", {b_bus.if_gnt, b_bus.d_gnt, b_bus.m_en, b_bus.if_rvalid, b_bus.d_rvalid}, 5'b0);
        check("abort_rst_rdata", {b_bus.if_rdata, b_bus.d_rdata}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        b_bus.if_req = 1; b_bus.if_addr = 16'h0009; b_bus.m_rdata = 16'hDEAD;
        #1;
        check("abort_first_gnt", b_bus.if_gnt, 1'b1);
        check("abort_first_addr", b_bus.m_addr, 16'h0009);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) b_bus.if_req = 0;
            b_bus.m_rdata = (k == 3) ? 16'h3333 : 16'hDEAD;
            #1;
            if (k < 4) begin
                check("abort_no_rvalid", b_bus.if_rvalid, 1'b0);
            end else begin
                check("abort_new_rvalid", b_bus.if_rvalid, 1'b1);
                check("abort_new_rdata", b_bus.if_rdata, 16'h3333);
            end
        end
        $display("abort: post-reset fetch rdata=%h", b_bus.if_rdata);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
